// File: rtl/bp_pe_pipe.sv
// Three-stage polar BP butterfly: min-sum f-updates of both L and R messages
// with optional 15/16 magnitude scaling, clamping to +/-MAX and a global-stall handshake.
module bp_pe_pipe #(
  parameter int W        = 20,
  parameter int FRAC     = 12,
  parameter int SCALE_EN = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     l1_i,
  input  logic [W-1:0]     l2_i,
  input  logic [W-1:0]     r1_i,
  input  logic [W-1:0]     r2_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     l1_o,
  output logic [W-1:0]     l2_o,
  output logic [W-1:0]     r1_o,
  output logic [W-1:0]     r2_o,
  output logic             sat_o,
  output logic [CNT_W-1:0] sat_cnt
);

  if (FRAC >= W) begin : g_bad_frac
    $error("FRAC must be smaller than W");
  end

  localparam logic [W-1:0]        MAX_V     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        MIN_V     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        NEG_MAX   = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [W:0]   MAX_X     = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   NEG_MAX_X = {2'b11, {(W-2){1'b0}}, 1'b1};

  function automatic logic signed [W:0] sx(input logic [W-1:0] v);
    return $signed({v[W-1], v});
  endfunction

  // Returns {clamp_event, clamped_value}.
  function automatic logic [W:0] clamp(input logic signed [W:0] x);
    logic [W:0] r;
    if (x > MAX_X)
      r = {1'b1, MAX_V};
    else if (x < NEG_MAX_X)
      r = {1'b1, NEG_MAX};
    else
      r = {1'b0, x[W-1:0]};
    return r;
  endfunction

  // Operands never equal MIN_V here, so their magnitudes fit in W bits.
  function automatic logic [W-1:0] fmin(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] m;
    ma = a[W-1] ? -a : a;
    mb = b[W-1] ? -b : b;
    m  = (ma < mb) ? ma : mb;
    if (SCALE_EN != 0)
      m = m - (m >> 4);
    return (a[W-1] ^ b[W-1]) ? -m : m;
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Index order: 0 = l1, 1 = l2, 2 = r1, 3 = r2.
  logic [W-1:0] in_raw [4];
  logic [W-1:0] in_fix [4];
  assign in_raw[0] = l1_i;
  assign in_raw[1] = l2_i;
  assign in_raw[2] = r1_i;
  assign in_raw[3] = r2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fix
      assign in_fix[gi] = (in_raw[gi] == MIN_V) ? NEG_MAX : in_raw[gi];
    end
  endgenerate

  logic [W:0] s_next;
  assign s_next = clamp(sx(in_fix[1]) + sx(in_fix[3]));

  logic         s1_valid_reg, s2_valid_reg;
  logic [W-1:0] s1_l1_reg, s1_l2_reg, s1_r1_reg, s1_r2_reg, s1_s_reg;
  logic         s1_sat_reg;
  logic [W-1:0] s2_fa_reg, s2_fb_reg, s2_fc_reg, s2_l2_reg, s2_r2_reg;
  logic         s2_sat_reg;

  logic [W:0] l2_sum_next, r2_sum_next;
  logic       sat3_next;
  assign l2_sum_next = clamp(sx(s2_fb_reg) + sx(s2_l2_reg));
  assign r2_sum_next = clamp(sx(s2_fb_reg) + sx(s2_r2_reg));
  assign sat3_next   = s2_sat_reg | l2_sum_next[W] | r2_sum_next[W];

  // Datapath registers need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_l1_reg  <= in_fix[0];
      s1_l2_reg  <= in_fix[1];
      s1_r1_reg  <= in_fix[2];
      s1_r2_reg  <= in_fix[3];
      s1_s_reg   <= s_next[W-1:0];
      s1_sat_reg <= s_next[W];
      s2_fa_reg  <= fmin(s1_l1_reg, s1_s_reg);
      s2_fb_reg  <= fmin(s1_r1_reg, s1_l1_reg);
      s2_fc_reg  <= fmin(s1_r1_reg, s1_s_reg);
      s2_l2_reg  <= s1_l2_reg;
      s2_r2_reg  <= s1_r2_reg;
      s2_sat_reg <= s1_sat_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      l1_o         <= '0;
      l2_o         <= '0;
      r1_o         <= '0;
      r2_o         <= '0;
      sat_o        <= 1'b0;
      sat_cnt      <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      out_valid    <= s2_valid_reg;
      l1_o         <= s2_fa_reg;
      l2_o         <= l2_sum_next[W-1:0];
      r1_o         <= s2_fc_reg;
      r2_o         <= r2_sum_next[W-1:0];
      sat_o        <= s2_valid_reg & sat3_next;
      if (s2_valid_reg && sat3_next && (sat_cnt != '1))
        sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_pe_pipe.sv
// Bench for bp_pe_pipe: an unscaled (CNT_W=16) and a scaled (CNT_W=2) instance
// share stimulus; expected beats go through a scoreboard queue.
module tb_bp_pe_pipe;
  localparam int W = 20;

  typedef struct packed {
    logic [W-1:0] l1;
    logic [W-1:0] l2;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         sat;
  } res_t;

  typedef struct {
    logic [W-1:0] l1;
    logic [W-1:0] l2;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    res_t         e0;
    res_t         e1;
  } vec_t;

  typedef struct {
    res_t e0;
    res_t e1;
    int   cnt;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] l1_i = '0, l2_i = '0, r1_i = '0, r2_i = '0;
  logic         in_ready0, out_valid0, sat_o0;
  logic         in_ready1, out_valid1, sat_o1;
  logic [W-1:0] l1_o0, l2_o0, r1_o0, r2_o0;
  logic [W-1:0] l1_o1, l2_o1, r1_o1, r2_o1;
  logic [15:0]  sat_cnt0;
  logic [1:0]   sat_cnt1;

  bp_pe_pipe #(.W(W), .FRAC(12), .SCALE_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .l1_i(l1_i), .l2_i(l2_i), .r1_i(r1_i), .r2_i(r2_i),
    .out_valid(out_valid0), .out_ready(out_ready),
    .l1_o(l1_o0), .l2_o(l2_o0), .r1_o(r1_o0), .r2_o(r2_o0),
    .sat_o(sat_o0), .sat_cnt(sat_cnt0)
  );

  bp_pe_pipe #(.W(W), .FRAC(12), .SCALE_EN(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .l1_i(l1_i), .l2_i(l2_i), .r1_i(r1_i), .r2_i(r2_i),
    .out_valid(out_valid1), .out_ready(out_ready),
    .l1_o(l1_o1), .l2_o(l2_o1), .r1_o(r1_o1), .r2_o(r2_o1),
    .sat_o(sat_o1), .sat_cnt(sat_cnt1)
  );

  int   errors = 0;
  int   checks = 0;
  int   cum = 0;
  bit   last_ov;
  sb_t  sbq[$];
  vec_t tbl[8];
  res_t zr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    int x;
    x = int'($signed(v));
    if (x == -(1 << (W-1))) x = -((1 << (W-1)) - 1);
    return x;
  endfunction

  function automatic int clampi(input int x, output bit hit);
    int mx;
    mx  = (1 << (W-1)) - 1;
    hit = (x > mx) || (x < -mx);
    if (x > mx) return mx;
    if (x < -mx) return -mx;
    return x;
  endfunction

  function automatic int fm(input int a, input int b, input bit sc);
    int ma, mb, m;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    m  = (ma < mb) ? ma : mb;
    if (sc) m = m - m / 16;
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  function automatic res_t model(input logic [W-1:0] l1, l2, r1, r2, input bit sc);
    int a, b, c, d, s, fa, fb, fc, o2, o4;
    bit h1, h2, h3;
    res_t r;
    a  = sval(l1); b = sval(l2); c = sval(r1); d = sval(r2);
    s  = clampi(b + d, h1);
    fa = fm(a, s, sc);
    fb = fm(c, a, sc);
    fc = fm(c, s, sc);
    o2 = clampi(fb + b, h2);
    o4 = clampi(fb + d, h3);
    r.l1 = fa[W-1:0];
    r.l2 = o2[W-1:0];
    r.r1 = fc[W-1:0];
    r.r2 = o4[W-1:0];
    r.sat = h1 | h2 | h3;
    return r;
  endfunction

  // One clock: drive at the falling edge, then sample #1 later; a beat transfers
  // at the next rising edge when the sampled handshake is true.
  task automatic cycle(input bit v, input logic [W-1:0] a, b, c, d,
                       input res_t e0, e1, input bit ordy, input bit rs, output bit acc);
    sb_t x;
    int  c1;
    @(negedge clk);
    rst = rs; in_valid = v; l1_i = a; l2_i = b; r1_i = c; r2_i = d; out_ready = ordy;
    #1;
    last_ov = out_valid0;
    chk("in_ready", {31'b0, in_ready0}, {31'b0, (!out_valid0 || out_ready)});
    chk("twin_valid", {31'b0, out_valid1}, {31'b0, out_valid0});
    if (!rs && out_valid0 && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_beat: got out_valid=1 with l1_o=%h, required no beat", l1_o0);
      end else begin
        x  = sbq.pop_front();
        c1 = (x.cnt > 3) ? 3 : x.cnt;
        chk("l1_o", l1_o0, x.e0.l1);
        chk("l2_o", l2_o0, x.e0.l2);
        chk("r1_o", r1_o0, x.e0.r1);
        chk("r2_o", r2_o0, x.e0.r2);
        chk("sat_o", {31'b0, sat_o0}, {31'b0, x.e0.sat});
        chk("sat_cnt", {16'b0, sat_cnt0}, x.cnt);
        chk("l1_o_scaled", l1_o1, x.e1.l1);
        chk("l2_o_scaled", l2_o1, x.e1.l2);
        chk("r1_o_scaled", r1_o1, x.e1.r1);
        chk("r2_o_scaled", r2_o1, x.e1.r2);
        chk("sat_o_scaled", {31'b0, sat_o1}, {31'b0, x.e1.sat});
        chk("sat_cnt_scaled", {30'b0, sat_cnt1}, c1);
      end
    end
    acc = v && !rs && in_ready0;
    if (acc) begin
      if (e0.sat) cum++;
      x.e0 = e0; x.e1 = e1; x.cnt = cum;
      sbq.push_back(x);
      $display("beat in: l1=%h l2=%h r1=%h r2=%h expect l1_o=%h l2_o=%h r1_o=%h r2_o=%h sat=%0d",
               a, b, c, d, e0.l1, e0.l2, e0.r1, e0.r2, e0.sat);
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, '0, '0, '0, '0, zr, zr, ordy, 1'b0, acc);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({tag, "_out_valid"}, {31'b0, out_valid0}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready0}, 32'd1);
    chk({tag, "_outs"}, {12'b0, l1_o0 | l2_o0 | r1_o0 | r2_o0}, 32'd0);
    chk({tag, "_sat_o"}, {31'b0, sat_o0}, 32'd0);
    chk({tag, "_sat_cnt"}, {16'b0, sat_cnt0}, 32'd0);
    chk({tag, "_scaled"}, {9'b0, out_valid1, sat_o1, sat_cnt1, l1_o1 | l2_o1 | r1_o1 | r2_o1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit               acc;
    bit               ov_seq [3];
    int               idx;
    int               n;
    logic [W-1:0]     bp [5][4];
    res_t             bp_e0 [5];
    res_t             bp_e1 [5];

    tbl[0] = '{20'h02000, 20'h01000, 20'hFE000, 20'h00800,
               '{20'h01800, 20'hFF000, 20'hFE800, 20'hFE800, 1'b0},
               '{20'h01680, 20'hFF200, 20'hFE980, 20'hFEA00, 1'b0}};
    tbl[1] = '{20'h00000, 20'h01000, 20'h01000, 20'hFF000,
               '{20'h00000, 20'h01000, 20'h00000, 20'hFF000, 1'b0},
               '{20'h00000, 20'h01000, 20'h00000, 20'hFF000, 1'b0}};
    tbl[2] = '{20'h01000, 20'h7F000, 20'h01000, 20'h7F000,
               '{20'h01000, 20'h7FFFF, 20'h01000, 20'h7FFFF, 1'b1},
               '{20'h00F00, 20'h7FF00, 20'h00F00, 20'h7FF00, 1'b1}};
    tbl[3] = '{20'h80000, 20'h01000, 20'h01000, 20'h00800,
               '{20'hFE800, 20'h00000, 20'h01000, 20'hFF800, 1'b0},
               '{20'hFE980, 20'h00100, 20'h00F00, 20'hFF900, 1'b0}};
    tbl[4] = '{20'h00800, 20'h80000, 20'hFF800, 20'hFF000,
               '{20'hFF800, 20'h80001, 20'h00800, 20'hFE800, 1'b1},
               '{20'hFF880, 20'h80001, 20'h00780, 20'hFE880, 1'b1}};
    tbl[5] = '{20'hFF000, 20'h00400, 20'hFD000, 20'h00C00,
               '{20'hFF000, 20'h01400, 20'hFF000, 20'h01C00, 1'b0},
               '{20'hFF100, 20'h01300, 20'hFF100, 20'h01B00, 1'b0}};
    tbl[6] = tbl[2];
    tbl[7] = tbl[4];

    // Reset with a valid beat present: the beat must be discarded.
    cycle(1'b1, tbl[0].l1, tbl[0].l2, tbl[0].r1, tbl[0].r2, tbl[0].e0, tbl[0].e1, 1'b1, 1'b1, acc);
    cycle(1'b1, tbl[0].l1, tbl[0].l2, tbl[0].r1, tbl[0].r2, tbl[0].e0, tbl[0].e1, 1'b1, 1'b1, acc);
    check_reset_state("reset");

    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].l1, tbl[i].l2, tbl[i].r1, tbl[i].r2, tbl[i].e0, tbl[i].e1, 1'b1, 1'b0, acc);
      chk("table_accept", {31'b0, acc}, 32'd1);
    end
    for (int k = 0; k < 20 && sbq.size() > 0; k++) idle(1'b1);
    chk("table_drain", sbq.size(), 32'd0);

    // Latency: out_valid rises exactly on the third cycle after acceptance.
    cycle(1'b1, tbl[0].l1, tbl[0].l2, tbl[0].r1, tbl[0].r2, tbl[0].e0, tbl[0].e1, 1'b1, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      ov_seq[k] = last_ov;
    end
    chk("latency_c1", {31'b0, ov_seq[0]}, 32'd0);
    chk("latency_c2", {31'b0, ov_seq[1]}, 32'd0);
    chk("latency_c3", {31'b0, ov_seq[2]}, 32'd1);

    // Back-pressure: five random beats against a stalled output.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) bp[i][j] = W'($urandom);
      if (i == 1) bp[i][1] = 20'h80000;
      if (i == 3) begin bp[i][1] = 20'h7C000; bp[i][3] = 20'h7C000; end
      bp_e0[i] = model(bp[i][0], bp[i][1], bp[i][2], bp[i][3], 1'b0);
      bp_e1[i] = model(bp[i][0], bp[i][1], bp[i][2], bp[i][3], 1'b1);
    end
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, bp[idx][0], bp[idx][1], bp[idx][2], bp[idx][3], bp_e0[idx], bp_e1[idx],
            1'b0, 1'b0, acc);
      if (acc) idx++;
      if (k >= 3 && sbq.size() > 0) chk("stall_hold_l2", l2_o0, sbq[0].e0.l2);
    end
    chk("bp_accepted", idx, 32'd3);
    n = 0;
    while ((idx < 5 || sbq.size() > 0) && n < 200) begin
      cycle(idx < 5, bp[idx < 5 ? idx : 0][0], bp[idx < 5 ? idx : 0][1],
            bp[idx < 5 ? idx : 0][2], bp[idx < 5 ? idx : 0][3],
            bp_e0[idx < 5 ? idx : 0], bp_e1[idx < 5 ? idx : 0],
            1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_sent", idx, 32'd5);
    chk("bp_drain", sbq.size(), 32'd0);

    // Reset with two beats in flight.
    cycle(1'b1, tbl[0].l1, tbl[0].l2, tbl[0].r1, tbl[0].r2, tbl[0].e0, tbl[0].e1, 1'b1, 1'b0, acc);
    cycle(1'b1, tbl[2].l1, tbl[2].l2, tbl[2].r1, tbl[2].r2, tbl[2].e0, tbl[2].e1, 1'b1, 1'b0, acc);
    cycle(1'b1, tbl[1].l1, tbl[1].l2, tbl[1].r1, tbl[1].r2, tbl[1].e0, tbl[1].e1, 1'b1, 1'b1, acc);
    sbq.delete();
    cum = 0;
    check_reset_state("midrst");
    for (int k = 0; k < 5; k++) begin
      idle(1'b1);
      chk("post_reset_quiet", {31'b0, last_ov}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
